// File: rtl/cbd_poly_sampler_pkg.sv
// Shared definitions for the centered-binomial polynomial sampler.
package cbd_poly_sampler_pkg;

  // Largest supported eta; each lane reads at most 2*ETA_MAX bits.
  localparam int ETA_MAX = 3;

  // Default polynomial geometry, used by words_per_poly.
  localparam int DEF_N_COEFFS   = 256;
  localparam int DEF_RAND_WIDTH = 128;

  // State enumeration, kept as plain constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Random words needed for one polynomial at the default geometry.
  function automatic int words_per_poly(input int eta);
    return (DEF_N_COEFFS * 2 * eta) / DEF_RAND_WIDTH;
  endfunction

endpackage

// File: rtl/cbd_poly_sampler_lane.sv
// One coefficient lane: popcount of the low half minus popcount of the high half.
module cbd_lane
  import cbd_poly_sampler_pkg::*;
#(
  parameter int COEF_WIDTH = 4
) (
  input  logic                         eta_sel,
  input  logic [2*ETA_MAX-1:0]         bits,
  output logic signed [COEF_WIDTH-1:0] coeff
);

  logic [1:0]        pos_cnt;
  logic [1:0]        neg_cnt;
  logic signed [3:0] diff;

  // eta 3 splits the six bits 3/3, eta 2 splits the low four bits 2/2.
  always_comb begin
    if (eta_sel) begin
      pos_cnt = {1'b0, bits[0]} + {1'b0, bits[1]} + {1'b0, bits[2]};
      neg_cnt = {1'b0, bits[3]} + {1'b0, bits[4]} + {1'b0, bits[5]};
    end else begin
      pos_cnt = {1'b0, bits[0]} + {1'b0, bits[1]};
      neg_cnt = {1'b0, bits[2]} + {1'b0, bits[3]};
    end
  end

  assign diff  = $signed({2'b00, pos_cnt}) - $signed({2'b00, neg_cnt});
  assign coeff = COEF_WIDTH'(diff);

endmodule

// File: rtl/cbd_poly_sampler.sv
// Centered-binomial polynomial sampler: turns a stream of random words into
// LANES signed coefficients per beat, eta 2 or eta 3, one polynomial per start.
module cbd_poly_sampler
  import cbd_poly_sampler_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int RAND_WIDTH = 128,
  parameter int N_COEFFS   = 256,
  parameter int COEF_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        eta_sel,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [RAND_WIDTH-1:0]       random_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*COEF_WIDTH-1:0] out_coeffs,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam int BUF_W    = RAND_WIDTH + 2 * ETA_MAX * LANES;
  localparam int N_GROUPS = N_COEFFS / LANES;
  localparam int FILL_W   = $clog2(BUF_W + 1);
  localparam int CNT_W    = $clog2(N_GROUPS + 1);

  state_t                      state;
  logic                        eta_q;
  logic [BUF_W-1:0]            bit_buf;
  logic [FILL_W-1:0]           fill;
  logic [CNT_W-1:0]            group_cnt;

  logic                        accept_in;
  logic                        out_fire;
  logic                        gen;
  logic [FILL_W-1:0]           g_bits;
  logic [FILL_W-1:0]           avail;
  logic [FILL_W-1:0]           fill_next;
  logic [BUF_W-1:0]            merged;
  logic [BUF_W-1:0]            buf_next;
  logic [LANES*COEF_WIDTH-1:0] lane_coeffs;

  // A whole word must fit above the current fill before it is accepted.
  assign in_ready  = (state == ST_RUN) && (fill <= FILL_W'(BUF_W - RAND_WIDTH));
  assign accept_in = in_ready && in_valid;
  assign out_fire  = out_valid && out_ready;
  assign g_bits    = eta_q ? FILL_W'(2 * 3 * LANES) : FILL_W'(2 * 2 * LANES);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  // The incoming word is merged in front of the lanes so a group can be
  // produced in the same cycle the word arrives, then the group is shifted out.
  always_comb begin
    merged = bit_buf;
    avail  = fill;
    if (accept_in) begin
      merged = bit_buf | ({{(BUF_W - RAND_WIDTH){1'b0}}, random_in} << fill);
      avail  = fill + FILL_W'(RAND_WIDTH);
    end
    gen = (state == ST_RUN) && (group_cnt < CNT_W'(N_GROUPS)) &&
          (avail >= g_bits) && (!out_valid || out_ready);
    buf_next  = merged;
    fill_next = avail;
    if (gen) begin
      buf_next  = eta_q ? (merged >> (2 * 3 * LANES)) : (merged >> (2 * 2 * LANES));
      fill_next = avail - g_bits;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [2*ETA_MAX-1:0] lane_bits;
    assign lane_bits = eta_q ? merged[6*i +: 6] : {2'b00, merged[4*i +: 4]};
    cbd_lane #(.COEF_WIDTH(COEF_WIDTH)) u_lane (
      .eta_sel (eta_q),
      .bits    (lane_bits),
      .coeff   (lane_coeffs[i*COEF_WIDTH +: COEF_WIDTH])
    );
  end

  // Control FSM, bit buffer, group counter and output register; clear wins over everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      eta_q      <= 1'b0;
      bit_buf    <= '0;
      fill       <= '0;
      group_cnt  <= '0;
      out_valid  <= 1'b0;
      out_coeffs <= '0;
      out_last   <= 1'b0;
    end else if (clear) begin
      state      <= ST_IDLE;
      bit_buf    <= '0;
      fill       <= '0;
      group_cnt  <= '0;
      out_valid  <= 1'b0;
      out_coeffs <= '0;
      out_last   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_RUN;
            eta_q      <= eta_sel;
            bit_buf    <= '0;
            fill       <= '0;
            group_cnt  <= '0;
            out_valid  <= 1'b0;
            out_coeffs <= '0;
            out_last   <= 1'b0;
          end
        end
        ST_RUN: begin
          bit_buf <= buf_next;
          fill    <= fill_next;
          if (gen) begin
            out_valid  <= 1'b1;
            out_coeffs <= lane_coeffs;
            out_last   <= (group_cnt == CNT_W'(N_GROUPS - 1));
            group_cnt  <= group_cnt + CNT_W'(1);
          end else if (out_fire) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
          if (out_fire && out_last) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          bit_buf   <= '0;
          fill      <= '0;
          group_cnt <= '0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cbd_poly_sampler.sv
// Directed bench for cbd_poly_sampler: constant-pattern table plus LFSR runs
// checked against a bit-serial reference, and stall/clear/reset sequences.
module tb_cbd_poly_sampler;
  import cbd_poly_sampler_pkg::*;

  localparam int N_GROUPS = 64;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic         eta_sel;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] random_in;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_coeffs;
  logic         out_last;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] words [12];
  logic [3:0]   exp_coef [256];

  typedef struct {
    logic         eta;
    logic [127:0] pattern;
    logic [3:0]   coef;
  } vec_t;

  vec_t vecs [6];

  cbd_poly_sampler dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .eta_sel    (eta_sel),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .random_in  (random_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_coeffs (out_coeffs),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic e, input logic c, input logic iv,
                                input logic [127:0] w, input logic ordy);
    start     = s;
    eta_sel   = e;
    clear     = c;
    in_valid  = iv;
    random_in = w;
    out_ready = ordy;
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  task automatic fill_const(input logic [127:0] pattern, input logic [3:0] coef);
    for (int w = 0; w < 12; w++) words[w] = pattern;
    for (int j = 0; j < 256; j++) exp_coef[j] = coef;
  endtask

  // Reference: treat all words as one LSB-first bitstream and slice it per coefficient.
  task automatic fill_lfsr(input logic [31:0] seed, input int eta);
    logic [31:0] s;
    int a, b, p;
    s = seed;
    for (int w = 0; w < 12; w++) begin
      for (int q = 0; q < 4; q++) begin
        for (int r = 0; r < 32; r++) s = lfsr_step(s);
        words[w][q*32 +: 32] = s;
      end
    end
    for (int j = 0; j < 256; j++) begin
      a = 0;
      b = 0;
      for (int k = 0; k < eta; k++) begin
        p = j * 2 * eta + k;
        a += int'(words[p / 128][p % 128]);
        p = p + eta;
        b += int'(words[p / 128][p % 128]);
      end
      exp_coef[j] = 4'(a - b);
    end
  endtask

  task automatic run_poly(input logic eta, input string tag, input int stall_at,
                          input int restart_at, input int abort_at, input int reset_at);
    int nwords, word_idx, grp, cyc, stall_left, t_in, t_out, both_hs;
    bit stall_active, held_ok, saw_ir_low, ended, restarted, early_done, late_bad;
    logic hs_in, hs_out;
    logic [15:0] held_coeffs, exp_grp;
    logic held_last;
    nwords = words_per_poly(eta ? 3 : 2);
    word_idx = 0; grp = 0; cyc = 0; stall_left = 0; t_in = -1; t_out = -1; both_hs = 0;
    stall_active = 0; held_ok = 0; saw_ir_low = 0; ended = 0; restarted = 0;
    early_done = 0; late_bad = 0; held_coeffs = '0; held_last = 1'b0;

    @(posedge clk); #1;
    apply_stimulus(1'b1, eta, 1'b0, 1'b0, '0, 1'b1);
    @(posedge clk); #1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    check_output({tag, "_busy_after_start"}, 32'(busy), 32'd1);

    while (!ended && cyc < 3000) begin
      in_valid  = (word_idx < nwords);
      random_in = in_valid ? words[word_idx] : '0;
      out_ready = !stall_active;
      if (restart_at >= 0 && grp == restart_at && !restarted) begin
        start = 1'b1; eta_sel = !eta; restarted = 1;
      end else begin
        start = 1'b0; eta_sel = 1'b0;
      end

      @(negedge clk);
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      if (done) early_done = 1;
      if (hs_in && t_in < 0) t_in = cyc;
      if (out_valid && t_out < 0) t_out = cyc;
      if (hs_in && hs_out) both_hs++;
      if (hs_in) word_idx++;
      if (stall_active) begin
        if (in_valid && !in_ready) saw_ir_low = 1;
        if (!held_ok) begin
          held_coeffs = out_coeffs; held_last = out_last; held_ok = 1;
        end else begin
          check_output({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
          check_output({tag, "_stall_hold"}, {15'd0, out_last, out_coeffs}, {15'd0, held_last, held_coeffs});
        end
        stall_left--;
        if (stall_left == 0) stall_active = 0;
      end
      if (hs_out) begin
        for (int k = 0; k < 4; k++) exp_grp[k*4 +: 4] = exp_coef[grp*4 + k];
        check_output($sformatf("%s_grp%0d", tag, grp), {15'd0, out_last, out_coeffs},
                     {15'd0, (grp == N_GROUPS - 1), exp_grp});
        grp++;
        if (grp == stall_at) begin
          stall_active = 1; stall_left = 10; held_ok = 0;
        end
      end

      @(posedge clk); #1;
      cyc++;
      if (hs_out && grp == N_GROUPS) begin
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        check_output({tag, "_done_pulse"}, {29'd0, done, busy, out_valid}, {29'd0, 1'b1, 1'b1, 1'b0});
        @(posedge clk); #1;
        @(negedge clk);
        check_output({tag, "_idle_after"}, {29'd0, done, busy, in_ready}, 32'd0);
        check_output({tag, "_words_used"}, 32'(word_idx), 32'(nwords));
        ended = 1;
      end else if (hs_out && grp == abort_at) begin
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, words[0], 1'b1);
        @(posedge clk); #1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        check_output({tag, "_clear_drop"}, {30'd0, out_valid, busy}, 32'd0);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          if (done || out_valid) late_bad = 1;
        end
        check_output({tag, "_no_done_after_clear"}, 32'(late_bad), 32'd0);
        ended = 1;
      end else if (hs_out && grp == reset_at) begin
        reset_n = 1'b0;
        #2;
        check_output({tag, "_reset_outputs"},
                     {11'd0, in_ready, out_valid, out_last, busy, done, out_coeffs}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, words[0], 1'b1);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          if (out_valid || busy || in_ready) late_bad = 1;
        end
        check_output({tag, "_quiet_after_reset"}, 32'(late_bad), 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        ended = 1;
      end
    end

    check_output({tag, "_timeout"}, 32'(ended), 32'd1);
    check_output({tag, "_early_done"}, 32'(early_done), 32'd0);
    if (abort_at < 0 && reset_at < 0) begin
      check_output({tag, "_latency"}, 32'(t_out - t_in), 32'd1);
      check_output({tag, "_dual_handshake_seen"}, 32'(both_hs > 0), 32'd1);
    end
    if (stall_at >= 0) begin
      check_output({tag, "_in_ready_backpressure"}, 32'(saw_ir_low), 32'd1);
    end
  endtask

  // Main sequence: reset, table of constant patterns, LFSR runs and corner cases.
  initial begin
    reset_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    vecs[0] = '{eta: 1'b0, pattern: '0,             coef: 4'h0};
    vecs[1] = '{eta: 1'b0, pattern: {16{8'h33}},    coef: 4'h2};
    vecs[2] = '{eta: 1'b0, pattern: {16{8'hCC}},    coef: 4'hE};
    vecs[3] = '{eta: 1'b1, pattern: {16{8'h55}},    coef: 4'h1};
    vecs[4] = '{eta: 1'b1, pattern: {16{8'hAA}},    coef: 4'hF};
    vecs[5] = '{eta: 1'b1, pattern: {128{1'b1}},    coef: 4'h0};

    #22;
    check_output("reset_outputs", {11'd0, in_ready, out_valid, out_last, busy, done, out_coeffs}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_output("idle_after_reset", {30'd0, busy, in_ready}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      fill_const(vecs[v].pattern, vecs[v].coef);
      run_poly(vecs[v].eta, $sformatf("vec%0d", v), -1, -1, -1, -1);
    end

    fill_lfsr(32'hACE1_1234, 3);
    run_poly(1'b1, "lfsr_eta3", -1, -1, -1, -1);

    fill_lfsr(32'h1357_9BDF, 2);
    run_poly(1'b0, "stall_eta2", 20, -1, -1, -1);

    fill_const({16{8'h33}}, 4'h2);
    run_poly(1'b0, "restart_clear", -1, 5, 20, -1);

    fill_lfsr(32'h0F0F_5A5A, 2);
    run_poly(1'b0, "reset_mid", -1, -1, -1, 10);

    fill_lfsr(32'h2468_ACE0, 3);
    run_poly(1'b1, "after_reset", -1, -1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cbd_poly_sampler.md
CBD_POLY_SAMPLER -- requirements
Module: cbd_poly_sampler

Interface
REQ-001 Parameter LANES, default 4: coefficients produced per output beat; must divide N_COEFFS.
REQ-002 Parameter RAND_WIDTH, default 128: random input word width in bits.
REQ-003 Parameter N_COEFFS, default 256: coefficients per polynomial.
REQ-004 Parameter COEF_WIDTH, default 4: two's-complement width of each coefficient; must be at least 4.
REQ-005 Port clk, input, 1 bit: the block's single clock; all state updates on its rising edge.
REQ-006 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port start, input, 1 bit: single-cycle pulse that begins one polynomial.
REQ-008 Port eta_sel, input, 1 bit: mode select, 0 = eta 2, 1 = eta 3; sampled only when start is accepted.
REQ-009 Port clear, input, 1 bit: synchronous abort back to IDLE.
REQ-010 Port in_valid, input, 1 bit: random_in holds a valid word.
REQ-011 Port in_ready, output, 1 bit: the block accepts a random word this cycle.
REQ-012 Port random_in, input, RAND_WIDTH bits: random bits, consumed LSB first.
REQ-013 Port out_valid, output, 1 bit: out_coeffs holds a valid group.
REQ-014 Port out_ready, input, 1 bit: downstream accepts the group.
REQ-015 Port out_coeffs, output, LANES*COEF_WIDTH bits: lane k occupies bits [k*COEF_WIDTH +: COEF_WIDTH].
REQ-016 Port out_last, output, 1 bit: qualifies the final group of the polynomial.
REQ-017 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-018 Port done, output, 1 bit: one-cycle pulse after the last group is accepted.

Function
REQ-019 The state machine SHALL have states IDLE, RUN and DONE.
- IDLE -> RUN on start; this transition clears the bit buffer, the fill count, the group counter and the output register.
- RUN -> DONE in the cycle after the last group handshake.
- DONE -> IDLE unconditionally one cycle later.
REQ-020 start SHALL be ignored outside IDLE, and eta_sel SHALL be latched only on an accepted start.
REQ-021 The bit buffer SHALL be BUF_W = RAND_WIDTH + 6*LANES bits wide, with a fill counter.
- in_ready = (state == RUN) and (fill + RAND_WIDTH <= BUF_W).
- An accepted word is appended above the existing fill; leftover bits carry across words.
REQ-022 A group SHALL consume G = LANES*2*eta bits from the buffer LSB.
- Generation occurs when fill >= G and the output register is empty or being accepted that cycle.
- Appending and consuming in the same cycle SHALL both take effect: fill' = fill + RAND_WIDTH - G.
REQ-023 Coefficient i within a group SHALL be computed as follows.
- a = popcount(bits[2*eta*i +: eta]) and b = popcount(bits[2*eta*i+eta +: eta]).
- The coefficient is a - b, sign-extended to COEF_WIDTH.
- Range: -2..2 for eta 2, -3..3 for eta 3.
REQ-024 Latency SHALL be one cycle: a word accepted in cycle t with sufficient fill gives out_valid in cycle t+1.
REQ-025 out_coeffs and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 out_last SHALL be high exactly on group N_COEFFS/LANES-1, and no group SHALL be generated beyond it.
REQ-027 The number of input words per polynomial SHALL be N_COEFFS*2*eta/RAND_WIDTH, i.e. 8 for eta 2 and 12 for eta 3 at the defaults.
- Any residual buffer bits at DONE are discarded.
REQ-028 clear SHALL take priority over start and over all handshakes.
- It returns the block to IDLE next cycle and drops out_valid.
- done is not asserted.

Reset
REQ-029 While reset_n=0, the outputs SHALL be in_ready=0, out_valid=0, out_coeffs=0, out_last=0, busy=0 and done=0.
REQ-030 While reset_n=0, the state SHALL be IDLE, and the fill count and group counter SHALL be 0.
REQ-031 An assertion of reset_n mid-polynomial SHALL abandon the polynomial; no partial output follows deassertion.

Structure
REQ-032 A shared package SHALL hold the following items.
- The state enumeration.
- ETA_MAX = 3.
- Function words_per_poly(eta).
REQ-033 A sub-module cbd_lane SHALL implement the per-coefficient popcount difference.
- Inputs: eta_sel and 6 bits.
- Output: a COEF_WIDTH signed value.
- It is instantiated LANES times.

Verification
REQ-034 eta 2, 8 all-zero words, out_ready=1 -> 64 groups with all coefficients 0; out_last on group 63; done one cycle after; busy low after.
REQ-035 eta 2, words 0x3333...33 -> every coefficient +2 (4'h2); words 0xCCCC...CC -> every coefficient -2 (4'hE).
REQ-036 eta 3, 12 LFSR words -> 256 coefficients match the golden model bit for bit, including lanes that straddle word boundaries.
REQ-037 out_ready held low 10 cycles mid-run -> out_coeffs stable; in_ready drops once fill + 128 > 152; no word is lost or duplicated.
REQ-038 Simultaneous in_valid/in_ready and out_valid/out_ready handshakes -> fill updated by +128-G in one cycle.
REQ-039 start re-pulsed during RUN is ignored; clear after 20 groups -> out_valid=0 next cycle and no done pulse.
REQ-040 reset_n pulsed low mid-run -> all outputs 0; a fresh start then produces correct results.
